// File: rtl/mult_fu_pipe.sv
// mult_fu_pipe: pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) for one complete_stage slot.
//
// Operands are extended to 2*XLEN bits at issue. Each stage multiplies the shifted multiplicand
// by a W-bit digit of the multiplier and adds the result into a running accumulator. After
// NUM_STAGE stages the accumulator holds the full 2*XLEN-bit product. Stages advance with
// per-stage handshakes, so bubbles collapse while the output is stalled.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   squash               flush all in-flight ops, drop a concurrent issue
//   issue_*              op from issue: valid, func (0 MUL,1 MULH,2 MULHSU,3 MULHU), rs1, rs2, dest
//   fu_ready             stage 0 can take an op this cycle (combinational)
//   fu_finish            result valid toward complete_stage
//   fu_c_stall           complete_stage did not take the result this cycle
//   out_dest_pr          destination physical register of the finishing op
//   out_dest_value       low half (MUL) or high half (MULH*) of the product
//   out_if_take_branch   always 0
module mult_fu_pipe #(
   parameter int unsigned NUM_STAGE = 4,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned PR        = 6
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            squash,
   input  logic            issue_valid,
   input  logic [1:0]      issue_func,
   input  logic [XLEN-1:0] issue_rs1,
   input  logic [XLEN-1:0] issue_rs2,
   input  logic [PR-1:0]   issue_dest_pr,
   output logic            fu_ready,
   output logic            fu_finish,
   input  logic            fu_c_stall,
   output logic [PR-1:0]   out_dest_pr,
   output logic [XLEN-1:0] out_dest_value,
   output logic            out_if_take_branch
);

   localparam int unsigned DW   = 2 * XLEN;
   localparam int unsigned W    = DW / NUM_STAGE;
   localparam int unsigned Last = NUM_STAGE - 1;

   localparam logic [1:0] FuncMul   = 2'd0;
   localparam logic [1:0] FuncMulh  = 2'd1;
   localparam logic [1:0] FuncMulhu = 2'd3;

   // Pipeline state, one entry per stage
   logic [NUM_STAGE-1:0] valid_q, valid_d;
   logic [1:0]           func_q   [NUM_STAGE];
   logic [1:0]           func_d   [NUM_STAGE];
   logic [PR-1:0]        pr_q     [NUM_STAGE];
   logic [PR-1:0]        pr_d     [NUM_STAGE];
   logic [DW-1:0]        mcand_q  [NUM_STAGE];
   logic [DW-1:0]        mcand_d  [NUM_STAGE];
   logic [DW-1:0]        mplier_q [NUM_STAGE];
   logic [DW-1:0]        mplier_d [NUM_STAGE];
   logic [DW-1:0]        acc_q    [NUM_STAGE];
   logic [DW-1:0]        acc_d    [NUM_STAGE];

   // Values that would be written into stage k if it loads this cycle
   logic [1:0]           step_func   [NUM_STAGE];
   logic [PR-1:0]        step_pr     [NUM_STAGE];
   logic [DW-1:0]        step_mcand  [NUM_STAGE];
   logic [DW-1:0]        step_mplier [NUM_STAGE];
   logic [DW-1:0]        step_acc    [NUM_STAGE];

   logic [NUM_STAGE-1:0] adv;   // stage k hands its op onward this cycle
   logic [NUM_STAGE-1:0] load;  // stage k receives a new op this cycle
   logic                 issue_acc;
   logic                 rs1_signed, rs2_signed;
   logic [DW-1:0]        ext_rs1, ext_rs2;

   // ------------------------------------------------------------------
   // Handshake: evaluated from the output backwards so a stage may move
   // into a slot that is being vacated in the same cycle.
   // ------------------------------------------------------------------
   always_comb begin : adv_comb
      logic moving;
      adv       = '0;
      moving    = valid_q[Last] & ~fu_c_stall;
      adv[Last] = moving;
      for (int k = int'(NUM_STAGE) - 2; k >= 0; k--) begin
         moving = valid_q[k] & (~valid_q[k+1] | moving);
         adv[k] = moving;
      end
   end

   assign fu_ready  = ~valid_q[0] | adv[0];
   assign issue_acc = issue_valid & fu_ready & ~squash;

   always_comb begin : load_comb
      load    = '0;
      load[0] = issue_acc;
      for (int k = 1; k < int'(NUM_STAGE); k++) begin
         load[k] = adv[k-1];
      end
   end

   // ------------------------------------------------------------------
   // Operand extension at issue
   // ------------------------------------------------------------------
   always_comb begin : ext_comb
      rs1_signed = (issue_func != FuncMulhu);
      rs2_signed = (issue_func == FuncMul) || (issue_func == FuncMulh);
      ext_rs1    = {{XLEN{rs1_signed & issue_rs1[XLEN-1]}}, issue_rs1};
      ext_rs2    = {{XLEN{rs2_signed & issue_rs2[XLEN-1]}}, issue_rs2};
   end

   // ------------------------------------------------------------------
   // Per-stage partial-product step. Products are truncated to DW bits;
   // with sign-extended operands this yields the exact signed product.
   // ------------------------------------------------------------------
   always_comb begin : step_comb
      step_func[0]   = issue_func;
      step_pr[0]     = issue_dest_pr;
      step_acc[0]    = ext_rs1 * DW'(ext_rs2[W-1:0]);
      step_mcand[0]  = ext_rs1 << W;
      step_mplier[0] = ext_rs2 >> W;
      for (int k = 1; k < int'(NUM_STAGE); k++) begin
         step_func[k]   = func_q[k-1];
         step_pr[k]     = pr_q[k-1];
         step_acc[k]    = acc_q[k-1] + mcand_q[k-1] * DW'(mplier_q[k-1][W-1:0]);
         step_mcand[k]  = mcand_q[k-1] << W;
         step_mplier[k] = mplier_q[k-1] >> W;
      end
   end

   // ------------------------------------------------------------------
   // Next state: load, drain, or hold
   // ------------------------------------------------------------------
   always_comb begin : next_comb
      valid_d = valid_q;
      for (int k = 0; k < int'(NUM_STAGE); k++) begin
         func_d[k]   = func_q[k];
         pr_d[k]     = pr_q[k];
         mcand_d[k]  = mcand_q[k];
         mplier_d[k] = mplier_q[k];
         acc_d[k]    = acc_q[k];
         if (load[k]) begin
            valid_d[k]  = 1'b1;
            func_d[k]   = step_func[k];
            pr_d[k]     = step_pr[k];
            mcand_d[k]  = step_mcand[k];
            mplier_d[k] = step_mplier[k];
            acc_d[k]    = step_acc[k];
         end else if (adv[k]) begin
            valid_d[k] = 1'b0;
         end
      end
      // Flush only invalidates; stale data fields are never observed
      if (squash) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         for (int k = 0; k < int'(NUM_STAGE); k++) begin
            func_q[k]   <= '0;
            pr_q[k]     <= '0;
            mcand_q[k]  <= '0;
            mplier_q[k] <= '0;
            acc_q[k]    <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < int'(NUM_STAGE); k++) begin
            func_q[k]   <= func_d[k];
            pr_q[k]     <= pr_d[k];
            mcand_q[k]  <= mcand_d[k];
            mplier_q[k] <= mplier_d[k];
            acc_q[k]    <= acc_d[k];
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs come straight from the last stage, so they hold under stall
   // ------------------------------------------------------------------
   always_comb begin : out_comb
      fu_finish          = valid_q[Last];
      out_dest_pr        = pr_q[Last];
      out_if_take_branch = 1'b0;
      if (func_q[Last] == FuncMul) begin
         out_dest_value = acc_q[Last][XLEN-1:0];
      end else begin
         out_dest_value = acc_q[Last][DW-1:XLEN];
      end
   end

endmodule
